// File: rtl/ps2_pkg.sv
// ps2_pkg: receiver state encoding, event record and PS/2 prefix codes.
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, DECODE} state_t;
  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } ev_t;
  localparam logic [7:0] PS2_BRK_CODE = 8'hF0;
  localparam logic [7:0] PS2_EXT_CODE = 8'hE0;
endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: show-ahead event FIFO; a push into a full FIFO is dropped
// with an ovf pulse unless a pop frees the head slot in the same cycle.
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_valid,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_full, w_pop, w_wr;
  assign w_full  = r_cnt == CW'(DEPTH);
  assign o_valid = r_cnt != '0;
  assign w_pop   = i_pop & o_valid;
  assign w_wr    = i_push & (~w_full | w_pop);
  assign o_ovf   = i_push & w_full & ~w_pop;
  assign o_count = r_cnt;
  assign o_data  = o_valid ? r_mem[r_rd] : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + CW'(w_wr) - CW'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr] <= i_data;
endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 frame receiver with F0/E0 prefix decoding into an event FIFO.
// Define PS2_PARITY_CHECK_EN to drop odd-parity-violating bytes with a par_err pulse.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ps2_clk,
  input  logic                       ps2_data,
  output logic [9:0]                 ev_data,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       frame_err,
  output logic                       par_err,
  output logic                       ovf
);
  localparam int TW = $clog2(TIMEOUT_CYC+1);
  logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync;
  logic                   r_clk_prev;
  state_t                 r_state, w_state_nxt;
  logic [7:0]             r_shift;
  logic [2:0]             r_bit;
  logic [TW-1:0]          r_to;
  logic                   r_brk, r_ext;
  logic                   w_edge, w_dat, w_timeout, w_par_ok;
  logic                   w_push, w_frame_err, w_set_brk, w_set_ext;
  ev_t                    w_ev;
  assign w_edge    = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
  assign w_dat     = r_dat_sync[SYNC_STAGES-1];
  assign w_timeout = (r_state != IDLE) && (r_to == TW'(TIMEOUT_CYC));
  assign w_ev      = '{brk: r_brk, ext: r_ext, code: r_shift};
  assign frame_err = w_frame_err;
`ifdef PS2_PARITY_CHECK_EN
  logic r_par;
  assign w_par_ok = ^{r_shift, r_par};
  assign par_err  = (r_state == DECODE) & ~w_par_ok;
`else
  assign w_par_ok = 1'b1;
  assign par_err  = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
    end
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_frame_err = 1'b0;
    w_set_brk   = 1'b0;
    w_set_ext   = 1'b0;
    if (w_timeout) begin
      w_state_nxt = IDLE;
      w_frame_err = 1'b1;
    end else
      case (r_state)
        IDLE:    w_state_nxt = (w_edge && !w_dat) ? DATA : IDLE;
        DATA:    w_state_nxt = (w_edge && r_bit == 3'd7) ? PARITY : DATA;
        PARITY:  w_state_nxt = w_edge ? STOP : PARITY;
        STOP: if (w_edge) begin
          w_state_nxt = w_dat ? DECODE : IDLE;
          w_frame_err = ~w_dat;
        end
        DECODE: begin
          w_state_nxt = IDLE;
          w_set_brk   = w_par_ok && r_shift == PS2_BRK_CODE;
          w_set_ext   = w_par_ok && r_shift == PS2_EXT_CODE;
          w_push      = w_par_ok && !w_set_brk && !w_set_ext;
        end
        default: w_state_nxt = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_to    <= '0;
      r_brk   <= 1'b0;
      r_ext   <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_to    <= (w_edge || r_state == IDLE) ? '0 : r_to + TW'(1);
      r_bit   <= (r_state == DATA && w_edge) ? r_bit + 3'd1 : (r_state == IDLE ? 3'd0 : r_bit);
      if (r_state == DATA && w_edge) r_shift <= {w_dat, r_shift[7:1]};
`ifdef PS2_PARITY_CHECK_EN
      if (r_state == PARITY && w_edge) r_par <= w_dat;
`endif
      r_brk   <= (w_frame_err | w_push) ? 1'b0 : (r_brk | w_set_brk);
      r_ext   <= (w_frame_err | w_push) ? 1'b0 : (r_ext | w_set_ext);
    end
  ps2_event_fifo #(.DEPTH(DEPTH), .WIDTH(10)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_data (w_ev),
    .i_pop  (ev_ready),
    .o_data (ev_data),
    .o_valid(ev_valid),
    .o_count(count),
    .o_ovf  (ovf)
  );
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: drives PS/2 frames and checks decoded events against a queue of expected events.
module tb_ps2_rx_fifo;
  localparam int DEPTH = 4;
  localparam int TO    = 300;
  localparam int HALF  = 10;
  logic       clk = 0, rst = 0, ps2_clk = 1, ps2_data = 1, ev_ready = 0;
  logic [9:0] ev_data;
  logic       ev_valid, frame_err, par_err, ovf;
  logic [2:0] count;
  int         n_tests = 0, n_fail = 0, fe_cnt = 0, pe_cnt = 0, ovf_cnt = 0;
  logic [9:0] exp_q[$];
  logic [9:0] exp;
  ps2_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ev_data(ev_data), .ev_valid(ev_valid), .ev_ready(ev_ready), .count(count),
    .frame_err(frame_err), .par_err(par_err), .ovf(ovf)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    fe_cnt  <= fe_cnt + int'(frame_err);
    pe_cnt  <= pe_cnt + int'(par_err);
    ovf_cnt <= ovf_cnt + int'(ovf);
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] code, input bit flip, input bit stopv, input int nedges);
    logic [10:0] f;
    f = {stopv, (~^code) ^ flip, code, 1'b0};
    for (int i = 0; i < nedges; i++) begin
      ps2_data = f[i];
      wait_cyc(HALF);
      ps2_clk = 0;
      wait_cyc(HALF);
      ps2_clk = 1;
    end
    wait_cyc(HALF);
    ps2_data = 1;
  endtask
  task automatic good(input logic [7:0] code);
    send_frame(code, 1'b0, 1'b1, 11);
  endtask
  task automatic pop();
    ev_ready = 1;
    @(negedge clk);
    ev_ready = 0;
  endtask
  task automatic test_reset();
    rst = 0;
    wait_cyc(3);
    n_tests++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ev_valid); end
    n_tests++; if (ev_data !== 10'h0) begin n_fail++; $display("FAIL reset_data: got %h want 000", ev_data); end
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_tests++; if ({frame_err, par_err, ovf} !== 3'b000) begin n_fail++; $display("FAIL reset_errs: got %b want 000", {frame_err, par_err, ovf}); end
    rst = 1;
    wait_cyc(3);
  endtask
  task automatic test_single();
    good(8'h1C); exp_q.push_back(10'h01C);
    n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", count); end
    exp = exp_q.pop_front();
    n_tests++; if (ev_valid !== 1'b1 || ev_data !== exp) begin n_fail++; $display("FAIL single_data: got v=%b %h want v=1 %h", ev_valid, ev_data, exp); end
    pop();
    n_tests++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b want 0", ev_valid); end
  endtask
  task automatic test_prefix();
    good(8'hE0); good(8'hF0);
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL prefix_nopush: got %0d want 0", count); end
    good(8'h74); exp_q.push_back(10'h374);
    n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL prefix_count: got %0d want 1", count); end
    exp = exp_q.pop_front();
    n_tests++; if (ev_data !== exp) begin n_fail++; $display("FAIL prefix_data: got %h want %h", ev_data, exp); end
    pop();
    good(8'h1C); exp_q.push_back(10'h01C);
    exp = exp_q.pop_front();
    n_tests++; if (ev_valid !== 1'b1 || ev_data !== exp) begin n_fail++; $display("FAIL prefix_cleared: got v=%b %h want v=1 %h", ev_valid, ev_data, exp); end
    pop();
  endtask
  task automatic test_parity();
    int pe0;
    pe0 = pe_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    wait_cyc(2);
`ifdef PS2_PARITY_CHECK_EN
    n_tests++; if (pe_cnt - pe0 !== 1) begin n_fail++; $display("FAIL parity_err: got %0d pulses want 1", pe_cnt - pe0); end
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL parity_drop: got %0d want 0", count); end
`else
    exp_q.push_back(10'h01C);
    n_tests++; if (pe_cnt - pe0 !== 0) begin n_fail++; $display("FAIL parity_err: got %0d pulses want 0", pe_cnt - pe0); end
    exp = exp_q.pop_front();
    n_tests++; if (ev_valid !== 1'b1 || ev_data !== exp) begin n_fail++; $display("FAIL parity_ignored: got v=%b %h want v=1 %h", ev_valid, ev_data, exp); end
    pop();
`endif
  endtask
  task automatic test_stop_err();
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'h33, 1'b0, 1'b0, 11);
    wait_cyc(2);
    n_tests++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL stop_err: got %0d pulses want 1", fe_cnt - fe0); end
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL stop_drop: got %0d want 0", count); end
  endtask
  task automatic test_timeout();
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'h2A, 1'b0, 1'b1, 5);
    wait_cyc(TO + 40);
    n_tests++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL timeout_err: got %0d pulses want 1", fe_cnt - fe0); end
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL timeout_drop: got %0d want 0", count); end
    good(8'h2A); exp_q.push_back(10'h02A);
    exp = exp_q.pop_front();
    n_tests++; if (ev_valid !== 1'b1 || ev_data !== exp) begin n_fail++; $display("FAIL timeout_next: got v=%b %h want v=1 %h", ev_valid, ev_data, exp); end
    pop();
  endtask
  task automatic test_overflow();
    logic [7:0] codes [4] = '{8'h15, 8'h1D, 8'h24, 8'h2D};
    int o0;
    o0 = ovf_cnt;
    for (int i = 0; i < 4; i++) begin
      good(codes[i]);
      exp_q.push_back({2'b00, codes[i]});
    end
    n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL ovf_fill: got %0d want 4", count); end
    n_tests++; if (ovf_cnt - o0 !== 0) begin n_fail++; $display("FAIL ovf_early: got %0d pulses want 0", ovf_cnt - o0); end
    good(8'h2C);
    n_tests++; if (ovf_cnt - o0 !== 1) begin n_fail++; $display("FAIL ovf_pulse: got %0d pulses want 1", ovf_cnt - o0); end
    n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d want 4", count); end
    for (int i = 0; i < 4; i++) begin
      exp = exp_q.pop_front();
      n_tests++; if (ev_valid !== 1'b1 || ev_data !== exp) begin n_fail++; $display("FAIL ovf_order%0d: got v=%b %h want v=1 %h", i, ev_valid, ev_data, exp); end
      pop();
    end
    n_tests++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %b want 0", ev_valid); end
  endtask
  task automatic test_reset_mid();
    good(8'h1C);
    send_frame(8'h5A, 1'b0, 1'b1, 6);
    rst = 0;
    wait_cyc(3);
    n_tests++; if ({ev_valid, ev_data, count, frame_err, par_err, ovf} !== '0) begin n_fail++; $display("FAIL midrst_outputs: got v=%b d=%h c=%0d e=%b want all 0", ev_valid, ev_data, count, {frame_err, par_err, ovf}); end
    rst = 1;
    wait_cyc(3);
    good(8'h5A); exp_q.push_back(10'h05A);
    n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL midrst_count: got %0d want 1", count); end
    exp = exp_q.pop_front();
    n_tests++; if (ev_data !== exp) begin n_fail++; $display("FAIL midrst_data: got %h want %h", ev_data, exp); end
    pop();
  endtask
  initial begin
    test_reset();
    test_single();
    test_prefix();
    test_parity();
    test_stop_err();
    test_timeout();
    test_overflow();
    test_reset_mid();
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
